// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the data-memory arbiter slice.
//   state_e  : arbiter FSM states (IDLE / ACCESS / RESP)
//   owner_e  : which requester owns the current access (CPU / debug host)
//   rr2_pick : two-way round-robin choice used by arb_rr2
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    // One-hot grant for two requesters; on a tie the one that did not go last wins.
    function automatic logic [1:0] rr2_pick(input logic [1:0] req, input owner_e last);
        logic [1:0] g;
        case (req)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = (last == OWN_DBG) ? 2'b01 : 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-requester round-robin arbiter (combinational pick + last-owner flop).
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   req[1:0]     : request vector (bit 0 = CPU, bit 1 = debug)
//   update       : record the current winner as last owner
//   grant[1:0]   : one-hot grant
//   gnt_idx      : index of the granted requester
// After reset the debug side counts as last owner, so the CPU wins the first tie.
module arb_rr2
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant,
    output logic       gnt_idx
);

    owner_e last_q;
    owner_e last_d;

    // Grant selection from the current requests and the last winner.
    always_comb begin
        grant   = rr2_pick(req, last_q);
        gnt_idx = grant[1];
    end

    // Next value of the last-owner record.
    always_comb begin
        last_d = last_q;
        if (update) begin
            last_d = owner_e'(gnt_idx);
        end else begin
            last_d = last_q;
        end
    end

    // Last-owner register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= OWN_DBG;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the MEM stage (CPU)
// and a debug/loader host, inserting WAIT_CYCLES extra cycles per access.
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata_i   : MEM-stage access; cpu_rdata_o valid when stall drops
//   cpu_stall_o               : pipeline freeze while a CPU access is outstanding
//   dbg_req/we/addr/wdata_i   : host access; dbg_rdata_o valid with dbg_ack_o pulse
//   mem_en/we/addr/wdata_o    : memory strobes, word-aligned address
//   mem_rdata_i               : combinational memory read data
//   stall_cnt_o               : saturating count of stalled cycles
// An access runs IDLE (grant) -> ACCESS (WAIT_CYCLES+1 cycles) -> RESP (1 cycle).
module dmem_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_ack_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int WC_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [WC_W-1:0]   WC_LOAD    = WC_W'(WAIT_CYCLES);
    // Misaligned addresses are aligned when latched; no error is raised.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [1:0] grant_s;
    logic       gnt_idx_s;
    logic       update_s;
    logic       final_s;
    logic       in_access_s;
    logic       cpu_stall_s;

    arb_rr2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({dbg_req_i, cpu_req_i}),
        .update  (update_s),
        .grant   (grant_s),
        .gnt_idx (gnt_idx_s)
    );

    // Access-phase decode and the combinational stall.
    always_comb begin
        in_access_s = (state_q == ACCESS);
        final_s     = in_access_s && (wait_cnt_q == {WC_W{1'b0}});
        // Gated by rst so the pipeline is not frozen while the block is held in reset.
        cpu_stall_s = rst && cpu_req_i && !((state_q == RESP) && (owner_q == OWN_CPU));
    end

    // FSM next state, request latching and read-data capture.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wait_cnt_d  = wait_cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        // The arbiter records the winner at grant time; it is only consulted in
        // IDLE, so this is equivalent to recording it at the end of the access.
        update_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_s != 2'b00) begin
                    update_s   = 1'b1;
                    owner_d    = owner_e'(gnt_idx_s);
                    wait_cnt_d = WC_LOAD;
                    state_d    = ACCESS;
                    if (gnt_idx_s == OWN_DBG) begin
                        we_d    = dbg_we_i;
                        addr_d  = dbg_addr_i & ALIGN_MASK;
                        wdata_d = dbg_wdata_i;
                    end else begin
                        we_d    = cpu_we_i;
                        addr_d  = cpu_addr_i & ALIGN_MASK;
                        wdata_d = cpu_wdata_i;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (wait_cnt_q != {WC_W{1'b0}}) begin
                    wait_cnt_d = wait_cnt_q - WC_W'(1);
                end else begin
                    state_d = RESP;
                    // Only reads refresh the owner's read-data register.
                    if (!we_q) begin
                        if (owner_q == OWN_CPU) begin
                            cpu_rdata_d = mem_rdata_i;
                        end else begin
                            dbg_rdata_d = mem_rdata_i;
                        end
                    end else begin
                        cpu_rdata_d = cpu_rdata_q;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Saturating stall-cycle counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cpu_stall_s && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            wait_cnt_q  <= {WC_W{1'b0}};
            cpu_rdata_q <= {DATA_W{1'b0}};
            dbg_rdata_q <= {DATA_W{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wait_cnt_q  <= wait_cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Output drive; memory strobes derive from the state flop so they drop
    // the instant reset asserts, and the write strobe exists only in the final ACCESS cycle.
    always_comb begin
        mem_en_o    = in_access_s;
        mem_we_o    = final_s && we_q;
        mem_addr_o  = in_access_s ? addr_q : {ADDR_W{1'b0}};
        mem_wdata_o = in_access_s ? wdata_q : {DATA_W{1'b0}};
        dbg_ack_o   = (state_q == RESP) && (owner_q == OWN_DBG);
        cpu_stall_o = cpu_stall_s;
        cpu_rdata_o = cpu_rdata_q;
        dbg_rdata_o = dbg_rdata_q;
        stall_cnt_o = stall_cnt_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter.
// Instance A uses WAIT_CYCLES=2, instance B uses WAIT_CYCLES=0; each has a
// small behavioural memory. Expected read data is queued when a request is
// driven and compared when the arbiter delivers it.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_init = 1'b1;
    always #5 clk = ~clk;

    // Instance A (WAIT_CYCLES = 2)
    logic          cpu_req_a = 1'b0, cpu_we_a = 1'b0;
    logic [AW-1:0] cpu_addr_a = '0;
    logic [DW-1:0] cpu_wdata_a = '0, cpu_rdata_a;
    logic          cpu_stall_a;
    logic          dbg_req_a = 1'b0, dbg_we_a = 1'b0;
    logic [AW-1:0] dbg_addr_a = '0;
    logic [DW-1:0] dbg_wdata_a = '0, dbg_rdata_a;
    logic          dbg_ack_a, mem_en_a, mem_we_a;
    logic [AW-1:0] mem_addr_a;
    logic [DW-1:0] mem_wdata_a, mem_rdata_a;
    logic [CW-1:0] stall_cnt_a;

    // Instance B (WAIT_CYCLES = 0)
    logic          cpu_req_b = 1'b0, cpu_we_b = 1'b0;
    logic [AW-1:0] cpu_addr_b = '0;
    logic [DW-1:0] cpu_wdata_b = '0, cpu_rdata_b;
    logic          cpu_stall_b;
    logic          dbg_req_b = 1'b0, dbg_we_b = 1'b0;
    logic [AW-1:0] dbg_addr_b = '0;
    logic [DW-1:0] dbg_wdata_b = '0, dbg_rdata_b;
    logic          dbg_ack_b, mem_en_b, mem_we_b;
    logic [AW-1:0] mem_addr_b;
    logic [DW-1:0] mem_wdata_b, mem_rdata_b;
    logic [CW-1:0] stall_cnt_b;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2), .CNT_W(CW)) u_dut_a (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req_a), .cpu_we_i(cpu_we_a), .cpu_addr_i(cpu_addr_a),
        .cpu_wdata_i(cpu_wdata_a), .cpu_rdata_o(cpu_rdata_a), .cpu_stall_o(cpu_stall_a),
        .dbg_req_i(dbg_req_a), .dbg_we_i(dbg_we_a), .dbg_addr_i(dbg_addr_a),
        .dbg_wdata_i(dbg_wdata_a), .dbg_rdata_o(dbg_rdata_a), .dbg_ack_o(dbg_ack_a),
        .mem_en_o(mem_en_a), .mem_we_o(mem_we_a), .mem_addr_o(mem_addr_a),
        .mem_wdata_o(mem_wdata_a), .mem_rdata_i(mem_rdata_a), .stall_cnt_o(stall_cnt_a)
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0), .CNT_W(CW)) u_dut_b (
        .clk(clk), .rst(rst),
        .cpu_req_i(cpu_req_b), .cpu_we_i(cpu_we_b), .cpu_addr_i(cpu_addr_b),
        .cpu_wdata_i(cpu_wdata_b), .cpu_rdata_o(cpu_rdata_b), .cpu_stall_o(cpu_stall_b),
        .dbg_req_i(dbg_req_b), .dbg_we_i(dbg_we_b), .dbg_addr_i(dbg_addr_b),
        .dbg_wdata_i(dbg_wdata_b), .dbg_rdata_o(dbg_rdata_b), .dbg_ack_o(dbg_ack_b),
        .mem_en_o(mem_en_b), .mem_we_o(mem_we_b), .mem_addr_o(mem_addr_b),
        .mem_wdata_o(mem_wdata_b), .mem_rdata_i(mem_rdata_b), .stall_cnt_o(stall_cnt_b)
    );

    // Behavioural memories: word i starts as 0x100+i, except word 0 which holds 5.
    logic [DW-1:0] mem_a [0:15];
    logic [DW-1:0] mem_b [0:15];
    assign mem_rdata_a = mem_a[mem_addr_a[5:2]];
    assign mem_rdata_b = mem_b[mem_addr_b[5:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) begin
                mem_a[i] <= (i == 0) ? 32'd5 : 32'h100 + i;
                mem_b[i] <= (i == 0) ? 32'd5 : 32'h100 + i;
            end
        end else begin
            if (mem_en_a && mem_we_a) mem_a[mem_addr_a[5:2]] <= mem_wdata_a;
            if (mem_en_b && mem_we_b) mem_b[mem_addr_b[5:2]] <= mem_wdata_b;
        end
    end

    // Write-strobe monitor for instance A.
    int            we_cnt_a = 0;
    logic [AW-1:0] last_we_addr_a = '0;
    always @(negedge clk) begin
        if (mem_en_a && mem_we_a) begin
            we_cnt_a       <= we_cnt_a + 1;
            last_we_addr_a <= mem_addr_a;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] cpu_q[$];
    logic [DW-1:0] dbg_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_cpu(input string tag, input logic [DW-1:0] got);
        logic [DW-1:0] exp;
        chk({tag, "_sb"}, 64'(cpu_q.size() != 0), 64'd1);
        if (cpu_q.size() != 0) begin
            exp = cpu_q.pop_front();
            chk(tag, 64'(got), 64'(exp));
        end
    endtask

    task automatic sb_dbg(input string tag, input logic [DW-1:0] got);
        logic [DW-1:0] exp;
        chk({tag, "_sb"}, 64'(dbg_q.size() != 0), 64'd1);
        if (dbg_q.size() != 0) begin
            exp = dbg_q.pop_front();
            chk(tag, 64'(got), 64'(exp));
        end
    endtask

    // One CPU access on instance A; expects WAIT_CYCLES+2 = 4 stalled cycles.
    task automatic cpu_a(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] exp_rd, input string tag);
        int stalls;
        bit done;
        stalls = 0;
        done   = 1'b0;
        @(posedge clk); #1;
        cpu_req_a = 1'b1; cpu_we_a = we; cpu_addr_a = addr; cpu_wdata_a = wdata;
        if (!we) cpu_q.push_back(exp_rd);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (cpu_stall_a) begin
                stalls++;
            end else begin
                done = 1'b1;
                if (!we) sb_cpu({tag, "_rdata"}, cpu_rdata_a);
            end
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_stalls"}, 64'(stalls), 64'd4);
        @(posedge clk); #1;
        cpu_req_a = 1'b0;
    endtask

    // One debug access on instance A; expects ack 4 cycles after the request.
    task automatic dbg_a(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] exp_rd, input string tag);
        int lat;
        bit stall_seen;
        lat        = -1;
        stall_seen = 1'b0;
        @(posedge clk); #1;
        dbg_req_a = 1'b1; dbg_we_a = we; dbg_addr_a = addr; dbg_wdata_a = wdata;
        if (!we) dbg_q.push_back(exp_rd);
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(negedge clk);
            if (cpu_stall_a) stall_seen = 1'b1;
            if (dbg_ack_a) begin
                lat = i;
                if (!we) sb_dbg({tag, "_rdata"}, dbg_rdata_a);
            end
        end
        chk({tag, "_ack_lat"}, 64'(lat), 64'd4);
        chk({tag, "_no_stall"}, 64'(stall_seen), 64'd0);
        @(posedge clk); #1;
        dbg_req_a = 1'b0;
    endtask

    initial begin
        int cpu_rel;
        int ack_at;
        int we_before;
        int nrel;
        logic [AW-1:0] first_addr;
        logic [5:0] st_vec;
        logic [5:0] en_vec;

        // Reset state, with a CPU request present during reset.
        repeat (3) @(posedge clk);
        #1;
        mem_init  = 1'b0;
        cpu_req_a = 1'b1;
        @(negedge clk);
        chk("rst_stall", 64'(cpu_stall_a), 64'd0);
        chk("rst_cnt", 64'(stall_cnt_a), 64'd0);
        chk("rst_mem_en", 64'(mem_en_a), 64'd0);
        chk("rst_ack", 64'(dbg_ack_a), 64'd0);
        chk("rst_cpu_rdata", 64'(cpu_rdata_a), 64'd0);
        chk("rst_dbg_rdata", 64'(dbg_rdata_a), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr_a), 64'd0);
        cpu_req_a = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        // Reset asserted in the middle of a CPU write to 0x08.
        @(posedge clk); #1;
        cpu_req_a = 1'b1; cpu_we_a = 1'b1; cpu_addr_a = 32'h08; cpu_wdata_a = 32'hDEAD_BEEF;
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rmid_stall", 64'(cpu_stall_a), 64'd0);
            chk("rmid_cnt", 64'(stall_cnt_a), 64'd0);
            chk("rmid_mem_we", 64'(mem_we_a), 64'd0);
        end
        chk("rmid_we_cnt", 64'(we_cnt_a), 64'd0);
        chk("rmid_mem08", 64'(mem_a[2]), 64'h102);
        cpu_req_a = 1'b0; cpu_we_a = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        // CPU load from 0x00 (holds 5); stall counter reflects 4 stalled cycles.
        cpu_a(1'b0, 32'h00, 32'h0, 32'd5, "lw00");
        chk("lw00_cnt", 64'(stall_cnt_a), 64'd4);

        // CPU store of 42 to misaligned 0x06 lands at word 0x04 with one strobe.
        we_before = we_cnt_a;
        cpu_a(1'b1, 32'h06, 32'h0000_002A, 32'h0, "sw06");
        chk("sw06_we_pulses", 64'(we_cnt_a - we_before), 64'd1);
        chk("sw06_we_addr", 64'(last_we_addr_a), 64'h04);
        chk("sw06_mem04", 64'(mem_a[1]), 64'd42);
        cpu_a(1'b0, 32'h04, 32'h0, 32'd42, "lw04");
        chk("lw04_cnt", 64'(stall_cnt_a), 64'd12);

        // Simultaneous requests right after reset: CPU first, then debug.
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        cpu_req_a = 1'b1; cpu_we_a = 1'b0; cpu_addr_a = 32'h00;
        dbg_req_a = 1'b1; dbg_we_a = 1'b0; dbg_addr_a = 32'h10;
        cpu_q.push_back(32'd5);
        dbg_q.push_back(32'h104);
        cpu_rel    = -1;
        ack_at     = -1;
        first_addr = '1;
        for (int i = 0; i < 30 && ack_at < 0; i++) begin
            @(negedge clk);
            if (i == 1) first_addr = mem_addr_a;
            if (dbg_ack_a) begin
                ack_at = i;
                sb_dbg("tie_dbg_rdata", dbg_rdata_a);
            end
            if (cpu_req_a && !cpu_stall_a) begin
                cpu_rel = i;
                sb_cpu("tie_cpu_rdata", cpu_rdata_a);
                @(posedge clk); #1;
                cpu_req_a = 1'b0;
            end
        end
        chk("tie_first_addr", 64'(first_addr), 64'h00);
        chk("tie_cpu_release", 64'(cpu_rel), 64'd4);
        chk("tie_dbg_ack_at", 64'(ack_at), 64'd9);
        @(posedge clk); #1;
        dbg_req_a = 1'b0;
        @(negedge clk);
        chk("tie_ack_one_cycle", 64'(dbg_ack_a), 64'd0);

        // Debug write then reads of 0x1C (aligned and misaligned).
        dbg_a(1'b1, 32'h1C, 32'h11, 32'h0, "dw1c");
        chk("dw1c_mem", 64'(mem_a[7]), 64'h11);
        dbg_a(1'b0, 32'h1C, 32'h0, 32'h11, "dr1c");
        dbg_a(1'b0, 32'h1F, 32'h0, 32'h11, "dr1f");

        // Instance B: back-to-back CPU loads with zero wait states.
        @(posedge clk); #1;
        cpu_req_b = 1'b1; cpu_we_b = 1'b0; cpu_addr_b = 32'h00;
        cpu_q.push_back(32'd5);
        cpu_q.push_back(32'h101);
        st_vec = '0;
        en_vec = '0;
        nrel   = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            st_vec[i] = cpu_stall_b;
            en_vec[i] = mem_en_b;
            if (!cpu_stall_b) begin
                nrel++;
                sb_cpu("b2b_rdata", cpu_rdata_b);
                cpu_addr_b = 32'h04;
            end
        end
        @(posedge clk); #1;
        cpu_req_b = 1'b0;
        chk("b2b_stall_pattern", 64'(st_vec), 64'b011011);
        chk("b2b_en_pattern", 64'(en_vec), 64'b010010);
        chk("b2b_releases", 64'(nrel), 64'd2);
        chk("b2b_cnt", 64'(stall_cnt_b), 64'd4);

        // Quiescent instance-B outputs and empty scoreboards.
        @(negedge clk);
        chk("b_idle_ack", 64'(dbg_ack_b), 64'd0);
        chk("b_idle_dbg_rdata", 64'(dbg_rdata_b), 64'd0);
        chk("b_idle_addr", 64'(mem_addr_b), 64'd0);
        chk("b_idle_wdata", 64'(mem_wdata_b), 64'd0);
        chk("b_idle_we", 64'(mem_we_b), 64'd0);
        chk("sb_cpu_left", 64'(cpu_q.size()), 64'd0);
        chk("sb_dbg_left", 64'(dbg_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog in case something upstream stops the clock-driven sequence.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (DataMem) between the pipeline MEM stage and a debug/loader host port.
- Adds a configurable number of wait states to every access.
- Sequences each access through a small FSM and raises a stall to the hazard logic while a CPU access is outstanding.
- Sits between the MEM stage / host and DataMem; the stall output is ORed into the pipeline freeze.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data word width
- WAIT_CYCLES, 2, extra memory cycles per access (0 allowed)
- CNT_W, 32, width of the performance counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req_i  in  1  MEM-stage access request (lw/sw)
- cpu_we_i  in  1  1 = write
- cpu_addr_i  in  ADDR_W  byte address
- cpu_wdata_i  in  DATA_W  store data
- cpu_rdata_o  out  DATA_W  load data, valid when stall releases
- cpu_stall_o  out  1  freeze pipeline
- dbg_req_i  in  1  host request
- dbg_we_i  in  1  host write
- dbg_addr_i  in  ADDR_W  host byte address
- dbg_wdata_i  in  DATA_W  host write data
- dbg_rdata_o  out  DATA_W  host read data, valid with ack
- dbg_ack_o  out  1  one-cycle completion pulse
- mem_en_o  out  1  memory enable
- mem_we_o  out  1  memory write strobe
- mem_addr_o  out  ADDR_W  word-aligned address
- mem_wdata_o  out  DATA_W  write data
- mem_rdata_i  in  DATA_W  combinational read data from memory
- stall_cnt_o  out  CNT_W  total cycles cpu_stall_o was high

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; last_owner=DBG, so the CPU wins the first tie.
  - All outputs 0, including rdata registers and stall_cnt_o.
  - mem_en_o and mem_we_o drop immediately, so no write occurs after reset assertion.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay.
  - One request: grant it.
  - Both requesting: grant the requester other than last_owner (2-way round-robin).
  - On grant: latch we, addr, wdata and owner; load wait_cnt=WAIT_CYCLES; go to ACCESS.
- ACCESS:
  - mem_en_o=1; mem_addr_o = latched addr with bits [1:0] forced to 0; mem_wdata_o = latched wdata.
  - wait_cnt decrements each cycle. While wait_cnt!=0, stay in ACCESS.
  - At wait_cnt==0 (final cycle):
    - mem_we_o = latched we (single write strobe, only in this cycle).
    - Read data is captured into the owner's rdata register.
    - Set last_owner=owner; go to RESP.
  - ACCESS lasts WAIT_CYCLES+1 cycles.
- RESP:
  - Exactly one cycle; mem_en_o=0.
  - If owner=DBG: dbg_ack_o=1.
  - If owner=CPU: cpu_stall_o=0, and cpu_rdata_o holds the load value.
  - Next state is always IDLE; a new grant can occur no earlier than the following cycle.
- cpu_stall_o is combinational: cpu_req_i AND NOT (state==RESP AND owner==CPU).
  - Stall is asserted in the same cycle the request appears.
  - CPU latency: stall high for WAIT_CYCLES+2 cycles, then low in RESP.
- Debug write latency: request to ack is WAIT_CYCLES+2 cycles.
- A request dropped after grant does not abort: the access still completes, including the write, and the response is discarded. dbg_ack_o still pulses only if owner=DBG.
- The non-granted requester waits with its request held. Starvation is bounded to one access.
- rdata registers hold their value until overwritten by the next read for the same owner.
- stall_cnt_o increments on every cycle with cpu_stall_o=1 and saturates at all-ones.
- Misaligned addresses are silently word-aligned; there is no error flag.

Decomposition:
- Shared package mips_pkg holds:
  - state encoding: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2
  - owner encoding: OWN_CPU=1'b0, OWN_DBG=1'b1
- Sub-module arb_rr2 (combinational pick plus last_owner register, 2 requesters):
  - inputs: req[1:0], update
  - outputs: grant[1:0], gnt_idx
  - Reusable for other shared resources.

Test Plan:
- Reset mid-ACCESS of a CPU write to 0x08 → mem_we_o never asserts; memory 0x08 unchanged; cpu_stall_o=0 and stall_cnt_o=0 while rst=0.
- CPU lw at 0x00 with memory 0x00=5, WAIT_CYCLES=2 → cpu_stall_o high 4 cycles, then cpu_rdata_o=5 in RESP; stall_cnt_o=4.
- CPU sw 0x0000002A to 0x06 → mem_addr_o=0x04; mem_we_o high exactly 1 cycle; memory 0x04 reads 42 afterwards.
- Simultaneous cpu and dbg requests after reset → CPU granted first. Debug is granted in the IDLE cycle after CPU's RESP; dbg_ack_o pulses 4 cycles later.
- dbg write 0x11 to 0x1C, then dbg read 0x1C → second dbg_ack_o with dbg_rdata_o=0x11; cpu_stall_o stays 0 throughout.
- WAIT_CYCLES=0 build, back-to-back CPU loads → each stalls exactly 2 cycles, with one IDLE cycle between accesses.
